// File: rtl/sr_cmd_conditioner.sv
// Command front-end for the NOR SR latch: synchronises, debounces and edge-detects two raw
// buttons, then issues registered, mutually exclusive S/R pulses with enforced width and gap.
module sr_cmd_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 2,
    parameter int GAP_CYCLES      = 1,
    parameter int RESET_PRIORITY  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_in,
    input  logic reset_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_model
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PH_MAX = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0]  PW_LAST  = PH_W'(PULSE_WIDTH - 1);
    localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Channel index 0 is the set button, index 1 the reset button.
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_p0 [2];
    logic [CNT_W-1:0]       deb_cnt [2];
    logic [1:0]             clean_p1;
    logic [1:0]             clean_d_p1;
    logic [1:0]             rise_c;
    logic [1:0]             rise_p2;
    logic [1:0]             pend;

    state_t                 state;
    logic [PH_W-1:0]        ph_cnt;
    logic                   take_s;
    logic                   take_r;

    assign raw    = {reset_in, set_in};
    assign rise_c = clean_p1 & ~clean_d_p1;

    // Synchroniser, debounce and edge-detect stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_p0[i] <= '0;
                deb_cnt[i] <= '0;
            end
            clean_p1   <= '0;
            clean_d_p1 <= '0;
            rise_p2    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_p0[i][SYNC_STAGES-1] == clean_p1[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    clean_p1[i] <= sync_p0[i][SYNC_STAGES-1];
                    deb_cnt[i]  <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
            clean_d_p1 <= clean_p1;
            rise_p2    <= rise_c;
        end
    end

    // Arbitration is only taken from IDLE; a simultaneous pair resolves by RESET_PRIORITY.
    always_comb begin
        take_r = 1'b0;
        take_s = 1'b0;
        if (state == IDLE) begin
            take_r = pend[1] && (!pend[0] || (RESET_PRIORITY != 0));
            take_s = pend[0] && !take_r;
        end
    end

    // Pending flags, pulse FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph_cnt   <= '0;
            pend     <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            q_model  <= 1'b0;
        end else begin
            busy     <= (state != IDLE) || (|pend);
            conflict <= rise_c[0] & rise_c[1];

            // A fresh edge wins over the clear of a request being served on the same edge.
            pend[0] <= rise_p2[0] ? 1'b1 : (take_s ? 1'b0 : pend[0]);
            pend[1] <= rise_p2[1] ? 1'b1 : (take_r ? 1'b0 : pend[1]);

            case (state)
                IDLE: begin
                    ph_cnt <= '0;
                    if (take_s) begin
                        state   <= PULSE_S;
                        s       <= 1'b1;
                        q_model <= 1'b1;
                    end else if (take_r) begin
                        state   <= PULSE_R;
                        r       <= 1'b1;
                        q_model <= 1'b0;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (ph_cnt == PW_LAST) begin
                        state  <= GAP;
                        ph_cnt <= '0;
                        s      <= 1'b0;
                        r      <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (ph_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ph_cnt <= '0;
                    s      <= 1'b0;
                    r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Scoreboard bench for sr_cmd_conditioner: default instance plus a swept-parameter instance,
// both driven by the same raw buttons and checked against a timing-level reference model.
module tb_sr_cmd_conditioner;

    localparam int SYNC = 2;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst_n;
    logic set_in;
    logic reset_in;
    logic s0, r0, b0, c0, q0;
    logic s1, r1, b1, c1, q1;

    always #5 clk = ~clk;

    sr_cmd_conditioner u_dut (
        .clk(clk), .rst_n(rst_n), .set_in(set_in), .reset_in(reset_in),
        .s(s0), .r(r0), .busy(b0), .conflict(c0), .q_model(q0)
    );

    sr_cmd_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .PULSE_WIDTH(3), .GAP_CYCLES(2), .RESET_PRIORITY(1)
    ) u_sweep (
        .clk(clk), .rst_n(rst_n), .set_in(set_in), .reset_in(reset_in),
        .s(s1), .r(r1), .busy(b1), .conflict(c1), .q_model(q1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    // Reference model state, [dut][channel]
    bit raw_h [2][HMAX];
    bit clean_m [2][2];
    bit pend_m  [2][2];
    int set_at  [2][2];
    int free_m  [2];
    int last_st [2];
    bit q_m     [2];
    bit busy_m  [2];
    int exp_q   [2][$];
    int conf_q  [2][$];

    // Monitor state
    bit s_prev [2];
    bit r_prev [2];
    int s_len  [2];
    int r_len  [2];
    int s_rise [2];

    function automatic int deb_of(int d);  return (d == 0) ? 4 : 1; endfunction
    function automatic int pw_of(int d);   return (d == 0) ? 2 : 3; endfunction
    function automatic int gap_of(int d);  return (d == 0) ? 1 : 2; endfunction

    function automatic bit sh(int ch, int x);
        if (x - (SYNC - 1) < 0) return 1'b0;
        return raw_h[ch][x - (SYNC - 1)];
    endfunction

    task automatic chk(string name, int d, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_clear(int d);
        for (int ch = 0; ch < 2; ch++) begin
            clean_m[d][ch] = 1'b0;
            pend_m[d][ch]  = 1'b0;
            set_at[d][ch]  = -1;
        end
        free_m[d]  = 0;
        last_st[d] = -1000;
        q_m[d]     = 1'b0;
        busy_m[d]  = 1'b0;
    endtask

    // Timing model: a clean edge becomes servable two edges later; pulses start when the
    // arbiter is free and hold it for width+gap+1 edges.
    task automatic model_step(int d, int e);
        int ch;
        bit rise [2];
        bit all_diff;
        busy_m[d] = ((e - 1 >= last_st[d]) && (e - 1 <= last_st[d] + pw_of(d) + gap_of(d) - 1))
                    || pend_m[d][0] || pend_m[d][1];
        if (e >= free_m[d] && (pend_m[d][0] || pend_m[d][1])) begin
            ch = pend_m[d][1] ? 1 : 0;
            exp_q[d].push_back(e * 2 + ch);
            pend_m[d][ch] = 1'b0;
            free_m[d]     = e + pw_of(d) + gap_of(d) + 1;
            last_st[d]    = e;
            q_m[d]        = (ch == 0);
        end
        for (int c = 0; c < 2; c++)
            if (set_at[d][c] == e) pend_m[d][c] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            rise[c]  = 1'b0;
            all_diff = 1'b1;
            for (int k = 1; k <= deb_of(d); k++)
                if (sh(c, e - k) == clean_m[d][c]) all_diff = 1'b0;
            if (all_diff) begin
                clean_m[d][c] = !clean_m[d][c];
                rise[c]       = clean_m[d][c];
                if (rise[c]) set_at[d][c] = e + 2;
            end
        end
        if (rise[0] && rise[1]) conf_q[d].push_back(e + 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            raw_h[0][cyc] = rst_n ? set_in : 1'b0;
            raw_h[1][cyc] = rst_n ? reset_in : 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) model_clear(d);
                else model_step(d, cyc);
            end
        end
    end

    task automatic mon_dut(int d, logic s, logic r, logic b, logic c, logic q);
        int item;
        chk("no_overlap", d, int'(s & r), 0);
        if (s && !s_prev[d]) begin
            s_rise[d] = cyc;
            if (exp_q[d].size() == 0) chk("s_unexpected", d, cyc * 2, -1);
            else begin item = exp_q[d].pop_front(); chk("s_start", d, cyc * 2, item); end
        end
        if (r && !r_prev[d]) begin
            if (exp_q[d].size() == 0) chk("r_unexpected", d, cyc * 2 + 1, -1);
            else begin item = exp_q[d].pop_front(); chk("r_start", d, cyc * 2 + 1, item); end
        end
        if (s) s_len[d]++;
        else if (s_prev[d]) begin chk("s_width", d, s_len[d], pw_of(d)); s_len[d] = 0; end
        if (r) r_len[d]++;
        else if (r_prev[d]) begin chk("r_width", d, r_len[d], pw_of(d)); r_len[d] = 0; end
        if (c) begin
            if (conf_q[d].size() == 0) chk("conflict_unexpected", d, cyc, -1);
            else begin item = conf_q[d].pop_front(); chk("conflict", d, cyc, item); end
        end
        chk("busy", d, b, busy_m[d]);
        chk("q_model", d, q, q_m[d]);
        s_prev[d] = s;
        r_prev[d] = r;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cyc >= 0) begin
                mon_dut(0, s0, r0, b0, c0, q0);
                mon_dut(1, s1, r1, b1, c1, q1);
            end else begin
                for (int d = 0; d < 2; d++) begin
                    s_prev[d] = 1'b0; r_prev[d] = 1'b0; s_len[d] = 0; r_len[d] = 0;
                end
            end
        end
    end

    task automatic drive(bit a, bit b, int n);
        set_in   = a;
        reset_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_s"}, 0, s0, 0);  chk({tag, "_r"}, 0, r0, 0);
        chk({tag, "_busy"}, 0, b0, 0); chk({tag, "_conf"}, 0, c0, 0);
        chk({tag, "_q"}, 0, q0, 0);
        chk({tag, "_s"}, 1, s1, 0);  chk({tag, "_r"}, 1, r1, 0);
        chk({tag, "_busy"}, 1, b1, 0); chk({tag, "_q"}, 1, q1, 0);
    endtask

    initial begin
        int start;
        bit a, b;
        set_in   = 1'b0;
        reset_in = 1'b0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) s_rise[d] = -1;
        repeat (3) @(negedge clk);
        #1 chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 4);

        // single set press; latency measured from first sampling edge
        start = cyc + 1;
        drive(1, 0, 20);
        drive(0, 0, 30);
        chk("latency_default", 0, s_rise[0] - start, 8);
        chk("latency_sweep", 1, s_rise[1] - start, 5);
        chk("q_after_set", 0, q0, 1);

        // bouncing reset button
        drive(0, 1, 3); drive(0, 0, 2); drive(0, 1, 3); drive(0, 0, 20);
        chk("deb_cnt_residue", 0, int'(u_dut.deb_cnt[1]), 0);
        chk("q_after_bounce", 0, q0, 1);

        // simultaneous press
        drive(1, 1, 20);
        drive(0, 0, 30);
        chk("q_after_simul", 0, q0, 1);

        // reset request arriving while the set pulse is in flight
        drive(1, 0, 1);
        drive(1, 1, 19);
        drive(0, 0, 30);
        chk("q_after_queued", 0, q0, 0);

        // random bouncy presses
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) a = !a;
            if ($urandom_range(0, 7) == 0) b = !b;
            drive(a, b, 1);
        end
        drive(0, 0, 40);

        // asynchronous reset while s is high
        set_in = 1'b1;
        for (int i = 0; i < 40 && !s0; i++) @(negedge clk);
        chk("mid_pulse_s_seen", 0, s0, 1);
        #2 rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            conf_q[d].delete();
        end
        #1 chk_zero_outputs("async_rst");
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        start = cyc + 1;
        drive(1, 0, 30);
        drive(0, 0, 40);
        chk("latency_after_reset", 0, s_rise[0] - start, 8);

        for (int d = 0; d < 2; d++) begin
            chk("unserved_pulses", d, exp_q[d].size(), 0);
            chk("unserved_conflicts", d, conf_q[d].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
